// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings, frame width, default rates and the
// tick divider computation, reused by the receiver and the future transmitter.
package uart_rx_pkg;

  localparam int DATA_BITS      = 8;
  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  function automatic int calc_div(int clk_freq, int baud, int oversample);
    return clk_freq / (baud * oversample);
  endfunction

  function automatic logic majority3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, with a
// synchronous restart that realigns the phase to a detected start edge.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver: pin synchroniser, start validation, 3-sample
// majority vote per bit, byte strobe and framing-error strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_output,
  output logic                 rx_recieved,
  output logic                 frame_err,
  output logic                 rx_busy,
  output logic [2:0]           state_dbg
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_FIRST = TW'(1);
  localparam logic [TW-1:0] T_V0    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_V1    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 sync1, rxs;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 v0, v1;
  logic                 restart, tick, sample;

  assign restart   = (state == S_IDLE) && !rxs;
  assign sample    = majority3(v0, v1, rxs);
  assign state_dbg = state;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
    end
  end

  // The detect cycle itself counts as tick 0, so the next divider tick is tick 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rx_output   <= '0;
      rx_recieved <= 1'b0;
      frame_err   <= 1'b0;
      rx_busy     <= 1'b0;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      v0          <= 1'b1;
      v1          <= 1'b1;
    end else begin
      rx_recieved <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state    <= S_START;
            rx_busy  <= 1'b1;
            tick_cnt <= T_FIRST;
            bit_idx  <= '0;
          end
        end
        S_START, S_DATA, S_STOP: begin
          if (tick) begin
            if (tick_cnt == T_V0) v0 <= rxs;
            if (tick_cnt == T_V1) v1 <= rxs;
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == T_DEC) begin
              case (state)
                S_START: begin
                  if (sample) begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                  end
                end
                S_DATA: shreg <= {sample, shreg[DATA_BITS-1:1]};
                default: begin
                  // Leave at mid stop bit so a following start edge is never missed.
                  if (sample) begin
                    rx_output   <= shreg;
                    rx_recieved <= 1'b1;
                    state       <= S_IDLE;
                    rx_busy     <= 1'b0;
                  end else begin
                    frame_err <= 1'b1;
                    state     <= S_BREAK;
                  end
                end
              endcase
            end
            if (tick_cnt == T_LAST) begin
              if (state == S_START) begin
                state   <= S_DATA;
                bit_idx <= '0;
              end else if (state == S_DATA) begin
                if (bit_idx == B_LAST) state <= S_STOP;
                else bit_idx <= bit_idx + 1'b1;
              end
            end
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
